// File: rtl/sar_pkg.sv
// Shared types and helpers for the SAR multi-channel scan sequencer.
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PICK   = 3'd1,
        SETTLE = 3'd2,
        START  = 3'd3,
        WAIT   = 3'd4,
        DONE   = 3'd5
    } sar_seq_state_t;

    // Bit width needed to index n items, never less than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sar_scan_sequencer_if.sv
// Host/ADC-facing signal bundle of the scan sequencer; the sequencer is the slave side.
interface sar_scan_sequencer_if #(
    parameter int ADC_WIDTH = 8,
    parameter int NUM_CH    = 4
);
    import sar_pkg::*;

    localparam int CH_W = clog2_min1(NUM_CH);

    // Strobes (scan_start, adc_start, adc_den, res_valid, scan_done) are single-cycle with
    // no backpressure: a strobe is consumed in the cycle it is high, its data is valid only then.
    logic                 scan_start;
    logic                 scan_cont;
    logic                 scan_abort;
    logic [NUM_CH-1:0]    ch_mask;
    logic [CH_W-1:0]      mux_sel;
    logic                 adc_start;
    logic                 adc_den;
    logic [ADC_WIDTH-1:0] adc_dout;
    logic                 busy;
    logic                 res_valid;
    logic [CH_W-1:0]      res_ch;
    logic [ADC_WIDTH-1:0] res_data;
    logic                 scan_done;
    logic                 err_timeout;
    sar_seq_state_t       state;

    modport master (
        output scan_start, scan_cont, scan_abort, ch_mask, adc_den, adc_dout,
        input  mux_sel, adc_start, busy, res_valid, res_ch, res_data, scan_done,
               err_timeout, state
    );

    modport slave (
        input  scan_start, scan_cont, scan_abort, ch_mask, adc_den, adc_dout,
        output mux_sel, adc_start, busy, res_valid, res_ch, res_data, scan_done,
               err_timeout, state
    );

endinterface

// File: rtl/sar_ch_picker.sv
// Combinational search for the lowest enabled channel at or above the pass pointer.
module sar_ch_picker
    import sar_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W  = clog2_min1(NUM_CH),
    localparam int PTR_W = clog2_min1(NUM_CH + 1)
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [PTR_W-1:0]  ptr,
    output logic              found,
    output logic [CH_W-1:0]   ch
);

    // Scan downward so the last hit, the lowest qualifying index, wins.
    always_comb begin
        found = 1'b0;
        ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (PTR_W'(i) >= ptr)) begin
                found = 1'b1;
                ch    = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/sar_scan_sequencer.sv
// Walks enabled mux channels, drives the SAR start pulse, averages results and
// reports one result per channel plus an end-of-pass pulse.
module sar_scan_sequencer
    import sar_pkg::*;
#(
    parameter int ADC_WIDTH     = 8,
    parameter int NUM_CH        = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int AVG_LOG2      = 0,
    parameter int TIMEOUT       = ADC_WIDTH + 4
) (
    input logic clk,
    input logic rst,
    sar_scan_sequencer_if.slave bus
);

    localparam int CH_W  = clog2_min1(NUM_CH);
    localparam int PTR_W = clog2_min1(NUM_CH + 1);
    localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
    localparam int SET_W = clog2_min1(SETTLE_CYCLES);
    localparam int TO_W  = clog2_min1(TIMEOUT);
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam logic [SMP_W-1:0] NUM_SMP = SMP_W'(1 << AVG_LOG2);

    sar_seq_state_t       state_q, state_d;
    logic [NUM_CH-1:0]    mask_q, mask_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [SET_W-1:0]     settle_q, settle_d;
    logic [TO_W-1:0]      to_q, to_d;
    logic [SMP_W-1:0]     smp_q, smp_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 res_valid_q, res_valid_d;
    logic [CH_W-1:0]      res_ch_q, res_ch_d;
    logic [ADC_WIDTH-1:0] res_data_q, res_data_d;
    logic                 err_q, err_d;

    logic                 pick_found;
    logic [CH_W-1:0]      pick_ch;
    logic [ACC_W-1:0]     acc_sum;
    logic [PTR_W-1:0]     ptr_after;

    sar_ch_picker #(
        .NUM_CH(NUM_CH)
    ) u_picker (
        .mask (mask_q),
        .ptr  (ptr_q),
        .found(pick_found),
        .ch   (pick_ch)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            ptr_q       <= '0;
            ch_q        <= '0;
            settle_q    <= '0;
            to_q        <= '0;
            smp_q       <= '0;
            acc_q       <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ptr_q       <= ptr_d;
            ch_q        <= ch_d;
            settle_q    <= settle_d;
            to_q        <= to_d;
            smp_q       <= smp_d;
            acc_q       <= acc_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        ptr_d       = ptr_q;
        ch_d        = ch_q;
        settle_d    = settle_q;
        to_d        = to_q;
        smp_d       = smp_q;
        acc_d       = acc_q;
        res_valid_d = 1'b0;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
        err_d       = err_q;
        acc_sum     = acc_q + ACC_W'(bus.adc_dout);
        ptr_after   = PTR_W'(ch_q) + PTR_W'(1);

        // Abort drops the partial accumulation but leaves the mux where it was.
        if (state_q != IDLE && bus.scan_abort) begin
            state_d = IDLE;
            acc_d   = '0;
            smp_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.scan_start) begin
                        mask_d  = bus.ch_mask;
                        err_d   = 1'b0;
                        ptr_d   = '0;
                        state_d = PICK;
                    end
                end
                PICK: begin
                    if (pick_found) begin
                        ch_d     = pick_ch;
                        settle_d = '0;
                        state_d  = SETTLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                SETTLE: begin
                    if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                        state_d = START;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                START: begin
                    to_d    = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (bus.adc_den) begin
                        if ((smp_q + SMP_W'(1)) < NUM_SMP) begin
                            // More samples due on this channel: mux already settled.
                            acc_d   = acc_sum;
                            smp_d   = smp_q + SMP_W'(1);
                            state_d = START;
                        end else begin
                            res_valid_d = 1'b1;
                            res_ch_d    = ch_q;
                            res_data_d  = ADC_WIDTH'(acc_sum >> AVG_LOG2);
                            acc_d       = '0;
                            smp_d       = '0;
                            ptr_d       = ptr_after;
                            state_d     = PICK;
                        end
                    end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        acc_d   = '0;
                        smp_d   = '0;
                        ptr_d   = ptr_after;
                        state_d = PICK;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
                DONE: begin
                    if (bus.scan_cont) begin
                        ptr_d   = '0;
                        state_d = PICK;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.mux_sel     = ch_q;
    assign bus.adc_start   = (state_q == START) && !bus.scan_abort;
    assign bus.busy        = (state_q != IDLE);
    assign bus.res_valid   = res_valid_q;
    assign bus.res_ch      = res_ch_q;
    assign bus.res_data    = res_data_q;
    assign bus.scan_done   = (state_q == DONE);
    assign bus.err_timeout = err_q;
    assign bus.state       = state_q;

endmodule
